// File: rtl/pin_id_pkg.sv
// Shared types and frame contents for the pin-identification beacon.
// PIN_ID_CHECKSUM_EN adds a fourth, XOR-checksum byte to every frame.
package pin_id_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

`ifdef PIN_ID_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 4;
`else
  localparam int unsigned FRAME_BYTES = 3;
`endif

  function automatic logic [7:0] frame_byte(input logic [15:0] ch_id,
                                            input logic [1:0]  byte_idx);
    logic [7:0] b;
    case (byte_idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = ch_id[7:0];
      2'd2:    b = ch_id[15:8];
`ifdef PIN_ID_CHECKSUM_EN
      default: b = SYNC_BYTE ^ ch_id[7:0] ^ ch_id[15:8];
`else
      default: b = 8'hFF;
`endif
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pin_id_baud_gen.sv
// Bit-period divider: counts DIV clocks per bit, bit_end marks the final clock.
// restart holds the count at zero so the first bit of a burst is full length.
module pin_id_baud_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/pin_id_beacon.sv
// Multi-channel pin-ID UART beacon: every tx bit sends sync, its own 16-bit index
// (and a checksum when PIN_ID_CHECKSUM_EN is defined), all channels in lockstep.
module pin_id_beacon
  import pin_id_pkg::*;
#(
  parameter int unsigned N_CH       = 194,
  parameter int unsigned CLK_HZ     = 24_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned PERIOD_CYC = 2_097_152
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            trigger,
  output logic [N_CH-1:0] tx,
  output logic            busy,
  output logic [15:0]     burst_cnt
);

  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned IW  = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [IW-1:0] IVL_LAST  = IW'(PERIOD_CYC - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(FRAME_BYTES - 1);

  if (DIV < 4) begin : g_div_check
    $error("pin_id_beacon: baud divisor %0d is below the minimum of 4", DIV);
  end

  tx_state_e       state, state_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [1:0]      byte_idx, byte_idx_d;
  logic            pending;
  logic [IW-1:0]   ivl_cnt;
  logic            ivl_hit, req, start, burst_done, bit_end;
  logic [N_CH-1:0] data_bits, tx_d;

  assign ivl_hit    = enable && (ivl_cnt == IVL_LAST);
  assign req        = trigger || ivl_hit;
  assign start      = (state == IDLE) && pending;
  assign burst_done = (state == STOP) && bit_end && (byte_idx == LAST_BYTE);

  pin_id_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (state == IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    case (state)
      IDLE: begin
        if (pending) begin
          state_d    = START;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx == LAST_BYTE) begin
            state_d = IDLE;
          end else begin
            state_d    = START;
            byte_idx_d = byte_idx + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data bits are decoded from the next-state indices so the tx flop lines up
  // with the state register; each channel's byte is a constant function of ch.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    localparam logic [15:0] CH_ID = 16'(ch);
    logic [7:0] fb;
    assign fb            = frame_byte(CH_ID, byte_idx_d);
    assign data_bits[ch] = fb[bit_idx_d];
  end

  always_comb begin
    case (state_d)
      START:   tx_d = '0;
      DATA:    tx_d = data_bits;
      default: tx_d = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      byte_idx  <= '0;
      pending   <= 1'b0;
      ivl_cnt   <= '0;
      tx        <= '1;
      busy      <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state    <= state_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      tx       <= tx_d;
      busy     <= (state_d != IDLE);
      pending  <= req || (pending && !start);
      if (!enable || ivl_hit) ivl_cnt <= '0;
      else                    ivl_cnt <= ivl_cnt + IW'(1);
      if (burst_done) burst_cnt <= burst_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pin_id_beacon.md
# pin_id_beacon

Parametrised multi-channel pin-identification transmitter for board bring-up. Every output channel repeatedly sends a short UART frame carrying its own channel index, so a probe or USB-UART on any unknown FPGA pin reads back which bit of the output bus it is attached to. It replaces the per-pin 8-bit transmitter array: one shared serializer, a 16-bit ID field (more than 256 pins), a sync byte, a programmable repeat interval and an external trigger. It sits between the PLL clock output and the top-level open-drain pin mapping.

## Interface
- N_CH, 194, number of output channels, 1..65535
- CLK_HZ, 24_000_000, clk frequency in Hz
- BAUD, 115_200, serial bit rate
- PERIOD_CYC, 2_097_152, clk cycles between burst starts in auto mode

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  auto-repeat bursts every PERIOD_CYC while high
- trigger  in  1  one-cycle pulse requests a single burst
- tx  out  N_CH  line level per channel, 1 = idle/release, 0 = pull low; top maps 0→drive 0, 1→high-Z
- busy  out  1  high while a burst is in progress
- burst_cnt  out  16  completed bursts, wraps at 0xFFFF→0

## Operation
- DIV = (CLK_HZ + BAUD/2) / BAUD, width $clog2(DIV+1); elaboration error if DIV < 4.
- Frame per channel i: byte0 = 0xA5 (sync), byte1 = i[7:0], byte2 = i[15:8], byte3 = checksum (macro only). Each byte is 8N1: start 0, 8 data LSB-first, stop 1.
- All channels serialize in lockstep: shared state, bit index and byte index; only the data bit differs per channel.
- FSM: IDLE → START → DATA (bits 0..7) → STOP → START of next byte, or back to IDLE after the last byte. No gap between bytes.
- Burst request = trigger pulse, or interval counter reaching PERIOD_CYC-1 while enable=1. The interval counter runs free while enable=1, clears when enable=0 and when it wraps.
- Request arriving while busy: latched in a single pending flag; the burst starts the cycle after the current one ends. Additional requests while pending are dropped.
- burst_cnt increments in the cycle STOP of the last byte ends.
- Reset: tx = all 1, busy = 0, burst_cnt = 0, state IDLE, interval counter 0, pending 0. Reset mid-burst releases every line on the next edge; no partial byte is completed.

## Timing
- Request registered at edge t → state START, busy = 1 and tx low at edge t+1.
- Each bit held exactly DIV cycles; baud divider restarts at every burst start.
- Burst length: BYTES × 10 × DIV cycles, BYTES = 3 (4 with checksum).
- busy falls on the same edge on which the last stop bit ends; pending burst's start bit follows on the next edge (one idle cycle minimum, tx = 1).
- If PERIOD_CYC < burst length, bursts run back-to-back via pending.

## Configuration
- PIN_ID_CHECKSUM_EN defined: 4-byte frame, byte3 = 0xA5 ^ i[7:0] ^ i[15:8].
- Undefined: 3-byte frame; no checksum logic.

## Structure
- Package pin_id_pkg: SYNC_BYTE = 8'hA5, state enum (IDLE, START, DATA, STOP), FRAME_BYTES constant selected by the macro, function frame_byte(ch_id, byte_idx).
- Sub-module pin_id_baud_gen: DIV-cycle divider with sync restart input, emits one-cycle bit_end tick.
- Per-channel data bit is generated combinationally from the channel index constant; no per-channel registers except the tx output flop.

## Test plan
- Params N_CH=4, CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), no macro; trigger pulse → tx[3] = 0 for 10 cycles, then bits A5, 03, 00 LSB-first with stop bits, 300 cycles total, busy high for 300 cycles, burst_cnt = 1.
- Same, PIN_ID_CHECKSUM_EN defined → tx[3] carries 4th byte 0xA6, tx[0] 4th byte 0xA5; burst 400 cycles.
- enable=1, PERIOD_CYC=1000 → bursts start at cycles 1000, 2000, 3000; burst_cnt = 3 after 3 bursts; enable=0 → no further starts.
- Trigger twice during a burst → exactly one extra burst, starting 1 cycle after busy falls; burst_cnt +2 total.
- Reset asserted at cycle 150 of a burst → next edge tx = 4'b1111, busy = 0, burst_cnt = 0; trigger after release → full correct frame.
- N_CH=300: tx[299] frame bytes A5, 2B, 01 decoded by bench UART model.
